branch_resolve: RTL and testbench

Execute-stage branch resolver. Consumes the 22-bit control bundle produced by the instruction-type decoders, together with PC, operands and immediate. Evaluates the branch/jump condition and registers the instruction into a one-entry valid/ready pipeline slot. Emits a one-cycle fetch redirect and squashes the wrong-path instructions that follow a taken branch.

---
 rtl/branch_resolve_if.sv | 47 ++++
 rtl/branch_resolve.sv | 142 ++++++++++++++
 tb/tb_branch_resolve.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// -----------------------------------------------------------------------------
// branch_resolve_if
// Bundles the upstream instruction handshake, the downstream slot handshake,
// the external flush and the fetch-redirect outputs of the branch resolver.
//   flush                      : external pipeline flush (trap)
//   in_valid / in_ready        : upstream handshake
//   in_ctrl[21:0]              : decoder control bundle
//   in_pc/in_rs1/in_rs2/in_imm : instruction PC, operands, immediate
//   out_valid / out_ready      : downstream handshake
//   out_ctrl, out_pc..out_imm  : registered instruction copy
//   out_taken, out_misalign    : branch outcome of the held instruction
//   redirect / redirect_pc     : one-cycle fetch redirect and its target
// Modports: master = instruction producer / consumer side, slave = resolver.
// -----------------------------------------------------------------------------
interface branch_resolve_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] in_ctrl;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [21:0] out_ctrl;
  logic [31:0] out_pc;
  logic [31:0] out_rs1;
  logic [31:0] out_rs2;
  logic [31:0] out_imm;
  logic        out_taken;
  logic        out_misalign;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output flush, in_valid, in_ctrl, in_pc, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_ctrl, out_pc, out_rs1, out_rs2, out_imm,
           out_taken, out_misalign, redirect, redirect_pc
  );

  modport slave (
    input  flush, in_valid, in_ctrl, in_pc, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_ctrl, out_pc, out_rs1, out_rs2, out_imm,
           out_taken, out_misalign, redirect, redirect_pc
  );
endinterface

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
// Execute-stage branch resolver. Evaluates the branch/jump condition of the
// incoming instruction, registers it into a one-entry valid/ready slot, emits
// a one-cycle fetch redirect for taken, aligned targets and then drops the
// next SHADOW accepted (wrong-path) instructions.
// Ports:
//   clk   : clock, rising edge
//   rstn  : asynchronous active-low reset
//   bus   : branch_resolve_if.slave (handshakes, operands, outputs, flush)
// Parameter:
//   SHADOW : number of accepted instructions dropped after a redirect (1..7)
// -----------------------------------------------------------------------------
module branch_resolve #(
  parameter int SHADOW = 2
) (
  input logic             clk,
  input logic             rstn,
  branch_resolve_if.slave bus
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_SHADOW = 1'b1;
  localparam logic [2:0] SQ_LOAD   = 3'(SHADOW);

  logic        r_vld_p1;
  logic [21:0] r_ctrl_p1;
  logic [31:0] r_pc_p1;
  logic [31:0] r_rs1_p1;
  logic [31:0] r_rs2_p1;
  logic [31:0] r_imm_p1;
  logic [31:0] r_tgt_p1;
  logic        r_taken_p1;
  logic        r_mis_p1;
  logic        r_redir_p1;
  logic [2:0]  r_sq_cnt;

  logic        w_in_ready;
  logic        w_accept;
  logic [0:0]  w_state;
  logic [31:0] w_tgt_p0;
  logic        w_taken_p0;
  logic        w_aligned_p0;
  logic        w_load;
  logic        w_drop;

  // Branch condition: 000 is an unconditional jump, 111 is reserved (never).
  function automatic logic br_cond(input logic [2:0]  op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = signed'(a);
    sb = signed'(b);
    case (op)
      3'b000:  br_cond = 1'b1;
      3'b001:  br_cond = (a == b);
      3'b010:  br_cond = (a != b);
      3'b011:  br_cond = (sa < sb);
      3'b100:  br_cond = (sa >= sb);
      3'b101:  br_cond = (a < b);
      3'b110:  br_cond = (a >= b);
      default: br_cond = 1'b0;
    endcase
  endfunction

  // ---- stage p0: condition evaluation and accept decision ----
  assign w_in_ready   = !r_vld_p1 || bus.out_ready;
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_state      = (r_sq_cnt == 3'd0) ? ST_RUN : ST_SHADOW;
  assign w_tgt_p0     = bus.in_pc + bus.in_imm;
  assign w_taken_p0   = bus.in_ctrl[19] && br_cond(bus.in_ctrl[11:9], bus.in_rs1, bus.in_rs2);
  assign w_aligned_p0 = (w_tgt_p0[1:0] == 2'b00);
  // In SHADOW an accepted instruction is consumed but never enters the slot.
  assign w_load       = w_accept && !bus.flush && (w_state == ST_RUN);
  assign w_drop       = w_accept && !bus.flush && (w_state == ST_SHADOW);

  // ---- stage p1: slot control, redirect pulse and squash counter ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_p1   <= 1'b0;
      r_taken_p1 <= 1'b0;
      r_mis_p1   <= 1'b0;
      r_redir_p1 <= 1'b0;
      r_sq_cnt   <= 3'd0;
    end else if (bus.flush) begin
      r_vld_p1   <= 1'b0;
      r_mis_p1   <= 1'b0;
      r_redir_p1 <= 1'b0;
      r_sq_cnt   <= 3'd0;
    end else begin
      // Pulse only on the load edge, so a stalled slot cannot repeat it.
      r_redir_p1 <= w_load && w_taken_p0 && w_aligned_p0;
      if (w_load) begin
        r_vld_p1   <= 1'b1;
        r_taken_p1 <= w_taken_p0;
        r_mis_p1   <= w_taken_p0 && !w_aligned_p0;
        if (w_taken_p0 && w_aligned_p0) begin
          r_sq_cnt <= SQ_LOAD;
        end
      end else begin
        if (bus.out_ready) begin
          r_vld_p1 <= 1'b0;
        end
        if (w_drop) begin
          r_sq_cnt <= r_sq_cnt - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ctrl_p1 <= '0;
      r_pc_p1   <= '0;
      r_rs1_p1  <= '0;
      r_rs2_p1  <= '0;
      r_imm_p1  <= '0;
      r_tgt_p1  <= '0;
    end else if (w_load) begin
      r_ctrl_p1 <= bus.in_ctrl;
      r_pc_p1   <= bus.in_pc;
      r_rs1_p1  <= bus.in_rs1;
      r_rs2_p1  <= bus.in_rs2;
      r_imm_p1  <= bus.in_imm;
      r_tgt_p1  <= w_tgt_p0;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_vld_p1;
  assign bus.out_ctrl     = r_ctrl_p1;
  assign bus.out_pc       = r_pc_p1;
  assign bus.out_rs1      = r_rs1_p1;
  assign bus.out_rs2      = r_rs2_p1;
  assign bus.out_imm      = r_imm_p1;
  assign bus.out_taken    = r_taken_p1;
  assign bus.out_misalign = r_mis_p1;
  assign bus.redirect     = r_redir_p1;
  assign bus.redirect_pc  = r_tgt_p1;

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

  localparam int SHADOW = 2;

  logic clk;
  logic rstn;

  branch_resolve_if bus();

  branch_resolve #(.SHADOW(SHADOW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  // Reference model state
  bit        m_vld;
  bit [21:0] m_ctrl;
  bit [31:0] m_pc, m_rs1, m_rs2, m_imm, m_rpc;
  bit        m_taken, m_mis, m_redir;
  int        m_skip;

  task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Condition from the rule table, using subtraction borrow for unsigned
  // and sign-bias for signed ordering.
  function automatic bit model_taken(bit npc, bit [2:0] op, bit [31:0] a, bit [31:0] b);
    bit [32:0] diff;
    bit lt_u, lt_s, c;
    diff = {1'b0, a} - {1'b0, b};
    lt_u = diff[32];
    lt_s = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
    case (op)
      3'd0: c = 1;
      3'd1: c = (a == b);
      3'd2: c = (a != b);
      3'd3: c = lt_s;
      3'd4: c = !lt_s;
      3'd5: c = lt_u;
      3'd6: c = !lt_u;
      default: c = 0;
    endcase
    return npc && c;
  endfunction

  task automatic model_reset();
    m_vld = 0; m_ctrl = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0;
    m_rpc = 0; m_taken = 0; m_mis = 0; m_redir = 0; m_skip = 0;
  endtask

  task automatic model_update();
    bit acc, tk;
    bit [31:0] tgt;
    if (!rstn) return;
    acc = bus.in_valid && (!m_vld || bus.out_ready);
    if (bus.flush) begin
      m_vld = 0; m_skip = 0; m_redir = 0; m_mis = 0;
      return;
    end
    m_redir = 0;
    if (m_vld && bus.out_ready) m_vld = 0;
    if (acc && m_skip > 0) begin
      m_skip--;
    end else if (acc) begin
      tk   = model_taken(bus.in_ctrl[19], bus.in_ctrl[11:9], bus.in_rs1, bus.in_rs2);
      tgt  = bus.in_pc + bus.in_imm;
      m_vld = 1; m_ctrl = bus.in_ctrl; m_pc = bus.in_pc; m_rs1 = bus.in_rs1;
      m_rs2 = bus.in_rs2; m_imm = bus.in_imm; m_rpc = tgt; m_taken = tk;
      m_mis   = tk && (tgt[1:0] != 2'b00);
      m_redir = tk && (tgt[1:0] == 2'b00);
      if (m_redir) m_skip = SHADOW;
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cycle",
        {bus.out_valid, bus.in_ready, bus.out_ctrl, bus.out_pc, bus.out_rs1, bus.out_rs2,
         bus.out_imm, bus.out_taken, bus.out_misalign, bus.redirect, bus.redirect_pc},
        {m_vld, (!m_vld || bus.out_ready), m_ctrl, m_pc, m_rs1, m_rs2,
         m_imm, m_taken, m_mis, m_redir, m_rpc});
    end
  end

  function automatic logic [21:0] mk(bit npc, bit [2:0] op);
    return {1'b1, 1'b0, npc, 3'b000, 4'b0000, op, 2'b00, 2'b00, 2'b00, 3'b000};
  endfunction

  task automatic drive(bit v, logic [21:0] ctrl, logic [31:0] pc, logic [31:0] a,
                       logic [31:0] b, logic [31:0] imm, bit ordy, bit fl);
    bus.in_valid = v; bus.in_ctrl = ctrl; bus.in_pc = pc; bus.in_rs1 = a;
    bus.in_rs2 = b; bus.in_imm = imm; bus.out_ready = ordy; bus.flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
  endtask

  bit [2:0] sg_op  [5] = '{3'b011, 3'b101, 3'b110, 3'b111, 3'b001};
  bit       sg_npc [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  bit       sg_exp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rstn = 1'b1;
    drive(0, '0, '0, '0, '0, '0, 1, 0);
    model_reset();
    #1 rstn = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_redirect", bus.redirect, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_ctrl", bus.out_ctrl, 0);
    check("rst_redirect_pc", bus.redirect_pc, 0);
    cmp_en = 1'b1;
    @(negedge clk); #1 rstn = 1'b1;

    // beq taken, two shadow drops, third instruction appears
    drive(1, mk(1, 3'b001), 32'h100, 5, 5, 32'h20, 1, 0); tick();
    check("beq_taken", bus.out_taken, 1);
    check("beq_redirect", bus.redirect, 1);
    check("beq_redirect_pc", bus.redirect_pc, 32'h120);
    check("beq_out_valid", bus.out_valid, 1);
    drive(1, mk(0, 3'b000), 32'h200, 0, 0, 4, 1, 0); tick();
    check("shadow1_dropped", bus.out_valid, 0);
    check("shadow1_no_redirect", bus.redirect, 0);
    drive(1, mk(0, 3'b000), 32'h204, 0, 0, 4, 1, 0); tick();
    check("shadow2_dropped", bus.out_valid, 0);
    drive(1, mk(0, 3'b000), 32'h208, 0, 0, 4, 1, 0); tick();
    check("third_valid", bus.out_valid, 1);
    check("third_pc", bus.out_pc, 32'h208);

    // Signed vs unsigned compares (misaligned target so nothing is squashed)
    for (int i = 0; i < 5; i++) begin
      drive(1, mk(sg_npc[i], sg_op[i]), 32'h300, 32'hFFFF_FFFF,
            (i == 4) ? 32'hFFFF_FFFF : 32'h1, 32'h2, 1, 0);
      tick();
      check($sformatf("cmp_taken_%0d", i), bus.out_taken, sg_exp[i]);
      check($sformatf("cmp_mis_%0d", i), bus.out_misalign, sg_exp[i]);
      check($sformatf("cmp_valid_%0d", i), bus.out_valid, 1);
    end

    // Stall after taken bne
    drive(1, mk(1, 3'b010), 32'h400, 1, 2, 32'h40, 1, 0); tick();
    check("bne_redirect", bus.redirect, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, mk(0, 3'b000), 32'h500, 0, 0, 4, 0, 0);
      #1 check($sformatf("stall_in_ready_%0d", i), bus.in_ready, 0);
      tick();
      check($sformatf("stall_redirect_%0d", i), bus.redirect, 0);
      check($sformatf("stall_pc_%0d", i), bus.out_pc, 32'h400);
      check($sformatf("stall_valid_%0d", i), bus.out_valid, 1);
    end
    drive(1, mk(0, 3'b000), 32'h500, 0, 0, 4, 1, 0);
    #1 check("release_in_ready", bus.in_ready, 1);
    tick();
    check("release_dropped", bus.out_valid, 0);
    drive(1, mk(0, 3'b000), 32'h504, 0, 0, 4, 1, 0); tick();
    drive(1, mk(0, 3'b000), 32'h508, 0, 0, 4, 1, 0); tick();
    check("after_stall_pc", bus.out_pc, 32'h508);

    // Misaligned jump: no redirect, no squash
    drive(1, mk(1, 3'b000), 32'h100, 0, 0, 32'h2, 1, 0); tick();
    check("mis_flag", bus.out_misalign, 1);
    check("mis_redirect", bus.redirect, 0);
    drive(1, mk(0, 3'b000), 32'h104, 0, 0, 4, 1, 0); tick();
    check("mis_next_valid", bus.out_valid, 1);
    check("mis_next_pc", bus.out_pc, 32'h104);

    // Flush colliding with a taken beq
    drive(1, mk(1, 3'b001), 32'h600, 9, 9, 32'h10, 1, 1); tick();
    check("flush_valid", bus.out_valid, 0);
    check("flush_redirect", bus.redirect, 0);
    drive(1, mk(0, 3'b000), 32'h700, 0, 0, 4, 1, 0); tick();
    check("post_flush_pc", bus.out_pc, 32'h700);
    check("post_flush_valid", bus.out_valid, 1);

    // Reset mid-SHADOW
    drive(1, mk(1, 3'b001), 32'h800, 3, 3, 32'h40, 1, 0); tick();
    drive(1, mk(0, 3'b000), 32'h900, 0, 0, 4, 1, 0); tick();
    rstn = 1'b0; model_reset();
    #1;
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_pc", bus.out_pc, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    @(negedge clk); #1 rstn = 1'b1;
    drive(1, mk(0, 3'b000), 32'h904, 0, 0, 4, 1, 0); tick();
    check("midrst_next_valid", bus.out_valid, 1);
    check("midrst_next_pc", bus.out_pc, 32'h904);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      logic [21:0] ctrl;
      logic [31:0] a, b, imm;
      int sel;
      ctrl = 22'($urandom);
      ctrl[19] = ($urandom_range(0, 3) != 0);
      ctrl[11:9] = 3'($urandom_range(0, 7));
      a = $urandom;
      sel = $urandom_range(0, 3);
      b = (sel == 0) ? a : (sel == 1) ? (a ^ 32'h8000_0000) : $urandom;
      imm = $urandom;
      if ($urandom_range(0, 3) != 0) imm[1:0] = 2'b00;
      drive($urandom_range(0, 3) != 0, ctrl, $urandom, a, b, imm,
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      tick();
      if ($urandom_range(0, 199) == 0) begin
        rstn = 1'b0; model_reset();
        #2 rstn = 1'b1;
      end
    end

    drive(0, '0, '0, '0, '0, '0, 1, 0);
    tick();
    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
